// File: rtl/shell_control.sv
// -----------------------------------------------------------------------------
// shell_control
//
// Purpose:
//   Flies one shell per tank across a (X_MAX+1) x (Y_MAX+1) grid. A rising
//   edge on the fire request launches a shell from the tank's position and
//   heading. The shell advances one cell per move_tick strobe until it either
//   leaves the grid (silently retired) or lands on the live target cell. A hit
//   raises a one-clock hit pulse and holds an explosion for EXPLODE_TICKS
//   move_ticks before the block re-arms. The busy flag (shell_state_o) is the
//   tank controller's shell feedback.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   move_tick_i     one-clock strobe; the shell advances one cell per strobe
//   shell_sht_i     fire request (level); only its rising edge launches
//   tank_x_i/_y_i   tank position, sampled on the fire cycle only
//   tank_dir_i      tank heading: 00 up, 01 down, 10 left, 11 right
//   target_valid_i  target cell is live
//   target_x_i/_y_i target cell, read live every cycle
//   shell_x_o/_y_o  current shell cell (holds last value while idle)
//   shell_dir_o     latched flight direction
//   shell_state_o   1 while a shell is flying or exploding
//   shell_hit_o     one-clock pulse when the shell hits the target
//   explode_o       1 while the explosion is being held
// -----------------------------------------------------------------------------
module shell_control #(
    parameter int X_MAX         = 24,
    parameter int Y_MAX         = 12,
    parameter int EXPLODE_TICKS = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       move_tick_i,
    input  logic       shell_sht_i,
    input  logic [4:0] tank_x_i,
    input  logic [4:0] tank_y_i,
    input  logic [1:0] tank_dir_i,
    input  logic       target_valid_i,
    input  logic [4:0] target_x_i,
    input  logic [4:0] target_y_i,
    output logic [4:0] shell_x_o,
    output logic [4:0] shell_y_o,
    output logic [1:0] shell_dir_o,
    output logic       shell_state_o,
    output logic       shell_hit_o,
    output logic       explode_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        EXPLODE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [4:0] X_LAST = 5'(X_MAX);
    localparam logic [4:0] Y_LAST = 5'(Y_MAX);

    // The explosion counter runs 0..EXPLODE_TICKS-1; the tick seen while it
    // holds the last value ends the explosion.
    localparam int             CNT_W    = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXPLODE_TICKS - 1);

    state_t           state_q;
    logic             shtDly_q;
    logic [4:0]       shellX_q;
    logic [4:0]       shellY_q;
    logic [1:0]       shellDir_q;
    logic             shellState_q;
    logic             shellHit_q;
    logic             explode_q;
    logic [CNT_W-1:0] tickCnt_q;

    logic             fire;
    logic             targetHit;
    logic             leavesGrid;
    logic [4:0]       shellX_d;
    logic [4:0]       shellY_d;

    // Fire detection, hit detection against the current cell, and the
    // candidate next cell. The bound check is done before any step so a
    // shell at the edge never computes a wrapped coordinate.
    always_comb begin
        fire       = shell_sht_i & ~shtDly_q;
        targetHit  = target_valid_i && (shellX_q == target_x_i) && (shellY_q == target_y_i);
        leavesGrid = 1'b0;
        shellX_d   = shellX_q;
        shellY_d   = shellY_q;
        case (shellDir_q)
            DIR_UP: begin
                if (shellY_q == 5'd0) leavesGrid = 1'b1;
                else                  shellY_d   = shellY_q - 5'd1;
            end
            DIR_DOWN: begin
                if (shellY_q == Y_LAST) leavesGrid = 1'b1;
                else                    shellY_d   = shellY_q + 5'd1;
            end
            DIR_LEFT: begin
                if (shellX_q == 5'd0) leavesGrid = 1'b1;
                else                  shellX_d   = shellX_q - 5'd1;
            end
            default: begin
                if (shellX_q == X_LAST) leavesGrid = 1'b1;
                else                    shellX_d   = shellX_q + 5'd1;
            end
        endcase
    end

    // Shell flight FSM with all outputs registered. The fire-edge history is
    // tracked in every state so a request held through re-arm cannot refire.
    // In FLY the hit check has priority over movement, which also makes a
    // shell spawned on the target cell hit without moving.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            shtDly_q     <= 1'b0;
            shellX_q     <= 5'd0;
            shellY_q     <= 5'd0;
            shellDir_q   <= 2'b00;
            shellState_q <= 1'b0;
            shellHit_q   <= 1'b0;
            explode_q    <= 1'b0;
            tickCnt_q    <= '0;
        end else begin
            shtDly_q   <= shell_sht_i;
            shellHit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        shellX_q     <= tank_x_i;
                        shellY_q     <= tank_y_i;
                        shellDir_q   <= tank_dir_i;
                        shellState_q <= 1'b1;
                        state_q      <= FLY;
                    end
                end
                FLY: begin
                    if (targetHit) begin
                        shellHit_q <= 1'b1;
                        explode_q  <= 1'b1;
                        tickCnt_q  <= '0;
                        state_q    <= EXPLODE;
                    end else if (move_tick_i) begin
                        if (leavesGrid) begin
                            shellState_q <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            shellX_q <= shellX_d;
                            shellY_q <= shellY_d;
                        end
                    end
                end
                EXPLODE: begin
                    if (move_tick_i) begin
                        if (tickCnt_q == CNT_LAST) begin
                            explode_q    <= 1'b0;
                            shellState_q <= 1'b0;
                            tickCnt_q    <= '0;
                            state_q      <= IDLE;
                        end else begin
                            tickCnt_q <= tickCnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    explode_q    <= 1'b0;
                    shellState_q <= 1'b0;
                    tickCnt_q    <= '0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign shell_x_o     = shellX_q;
    assign shell_y_o     = shellY_q;
    assign shell_dir_o   = shellDir_q;
    assign shell_state_o = shellState_q;
    assign shell_hit_o   = shellHit_q;
    assign explode_o     = explode_q;

endmodule

// File: tb/tb_shell_control.sv
// -----------------------------------------------------------------------------
// tb_shell_control
//
// Purpose:
//   Directed, self-checking bench for shell_control. Inputs are changed 1 ns
//   after a rising edge and outputs are checked at the same point, so each
//   check sees the registered result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_shell_control;

    logic       clk;
    logic       rst;
    logic       moveTick;
    logic       shellSht;
    logic [4:0] tankX;
    logic [4:0] tankY;
    logic [1:0] tankDir;
    logic       targetValid;
    logic [4:0] targetX;
    logic [4:0] targetY;
    logic [4:0] shellX;
    logic [4:0] shellY;
    logic [1:0] shellDir;
    logic       shellState;
    logic       shellHit;
    logic       explode;

    int assertCount = 0;
    int failCount   = 0;

    shell_control #(
        .X_MAX(24),
        .Y_MAX(12),
        .EXPLODE_TICKS(3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .move_tick_i(moveTick),
        .shell_sht_i(shellSht),
        .tank_x_i(tankX),
        .tank_y_i(tankY),
        .tank_dir_i(tankDir),
        .target_valid_i(targetValid),
        .target_x_i(targetX),
        .target_y_i(targetY),
        .shell_x_o(shellX),
        .shell_y_o(shellY),
        .shell_dir_o(shellDir),
        .shell_state_o(shellState),
        .shell_hit_o(shellHit),
        .explode_o(explode)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive fire request and move strobe for one clock, then settle 1 ns past the edge
    task automatic applyStimulus(input logic sht, input logic tick);
        shellSht = sht;
        moveTick = tick;
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and report it if the observed value differs
    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Position and busy flag together
    task automatic checkPos(input string tag, input int x, input int y, input int st);
        checkOutput({tag, ".x"}, int'(shellX), x);
        checkOutput({tag, ".y"}, int'(shellY), y);
        checkOutput({tag, ".state"}, int'(shellState), st);
    endtask

    // Busy, hit pulse and explosion flags together
    task automatic checkFlags(input string tag, input int st, input int hit, input int ex);
        checkOutput({tag, ".state"}, int'(shellState), st);
        checkOutput({tag, ".hit"}, int'(shellHit), hit);
        checkOutput({tag, ".explode"}, int'(explode), ex);
    endtask

    // Directed sequence
    initial begin
        rst         = 1'b1;
        moveTick    = 1'b0;
        shellSht    = 1'b0;
        tankX       = 5'd0;
        tankY       = 5'd0;
        tankDir     = 2'b00;
        targetValid = 1'b0;
        targetX     = 5'd0;
        targetY     = 5'd0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkPos("reset", 0, 0, 0);
        checkFlags("reset", 0, 0, 0);
        checkOutput("reset.dir", int'(shellDir), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // T1: reset in the middle of a flight
        $display("[TB] T1 reset mid-flight");
        tankX = 5'd7; tankY = 5'd5; tankDir = 2'b11;
        applyStimulus(1'b1, 1'b0);
        checkPos("t1.fly", 7, 5, 1);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkPos("t1.rst", 0, 0, 0);
        checkFlags("t1.rst", 0, 0, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1.idle", int'(shellState), 0);

        // T2: fly right off the grid edge
        $display("[TB] T2 fly right");
        tankX = 5'd20; tankY = 5'd3; tankDir = 2'b11;
        applyStimulus(1'b1, 1'b0);
        checkPos("t2.spawn", 20, 3, 1);
        checkOutput("t2.dir", int'(shellDir), 3);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkPos($sformatf("t2.step%0d", i), 20 + i, 3, 1);
        end
        applyStimulus(1'b0, 1'b1);
        checkPos("t2.exit", 24, 3, 0);
        checkFlags("t2.exit", 0, 0, 0);

        // T3: fly up into the target, explode for three ticks
        $display("[TB] T3 hit");
        targetValid = 1'b1; targetX = 5'd2; targetY = 5'd4;
        tankX = 5'd2; tankY = 5'd6; tankDir = 2'b00;
        applyStimulus(1'b1, 1'b0);
        checkPos("t3.spawn", 2, 6, 1);
        checkFlags("t3.spawn", 1, 0, 0);
        applyStimulus(1'b0, 1'b1);
        checkPos("t3.step1", 2, 5, 1);
        applyStimulus(1'b0, 1'b1);
        checkPos("t3.step2", 2, 4, 1);
        checkFlags("t3.step2", 1, 0, 0);
        applyStimulus(1'b0, 1'b0);
        checkFlags("t3.hit", 1, 1, 1);
        checkPos("t3.hit", 2, 4, 1);
        applyStimulus(1'b0, 1'b0);
        checkFlags("t3.after", 1, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t3.tick1", 1, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t3.tick2", 1, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t3.tick3", 0, 0, 0);
        targetValid = 1'b0;

        // T4: held request fires once; a fresh edge fires again
        $display("[TB] T4 held request");
        tankX = 5'd10; tankY = 5'd6; tankDir = 2'b01;
        applyStimulus(1'b1, 1'b0);
        checkPos("t4.spawn", 10, 6, 1);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b1);
        end
        checkPos("t4.edge", 10, 12, 1);
        applyStimulus(1'b1, 1'b1);
        checkPos("t4.exit", 10, 12, 0);
        tankX = 5'd1; tankY = 5'd1; tankDir = 2'b10;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkPos("t4.held", 10, 12, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t4.drop", int'(shellState), 0);
        applyStimulus(1'b1, 1'b0);
        checkPos("t4.refire", 1, 1, 1);
        checkOutput("t4.dir", int'(shellDir), 2);
        applyStimulus(1'b0, 1'b1);
        checkPos("t4.left", 0, 1, 1);
        applyStimulus(1'b0, 1'b1);
        checkPos("t4.exit2", 0, 1, 0);

        // T5: fire requests while busy are ignored
        $display("[TB] T5 busy ignore");
        targetValid = 1'b1; targetX = 5'd7; targetY = 5'd5;
        tankX = 5'd5; tankY = 5'd5; tankDir = 2'b11;
        applyStimulus(1'b1, 1'b0);
        checkPos("t5.spawn", 5, 5, 1);
        applyStimulus(1'b0, 1'b0);
        tankX = 5'd15; tankY = 5'd10; tankDir = 2'b00;
        applyStimulus(1'b1, 1'b0);
        checkPos("t5.flyfire", 5, 5, 1);
        checkOutput("t5.flydir", int'(shellDir), 3);
        applyStimulus(1'b0, 1'b1);
        checkPos("t5.step1", 6, 5, 1);
        applyStimulus(1'b0, 1'b1);
        checkPos("t5.step2", 7, 5, 1);
        applyStimulus(1'b0, 1'b0);
        checkFlags("t5.hit", 1, 1, 1);
        applyStimulus(1'b1, 1'b0);
        checkFlags("t5.exfire", 1, 0, 1);
        checkPos("t5.exfire", 7, 5, 1);
        checkOutput("t5.exdir", int'(shellDir), 3);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t5.tick2", 1, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t5.done", 0, 0, 0);
        applyStimulus(1'b0, 1'b0);
        checkPos("t5.noqueue", 7, 5, 0);
        targetValid = 1'b0;

        // T6: spawn with same-cycle tick at the corner, then spawn on the target
        $display("[TB] T6 edge cases");
        tankX = 5'd0; tankY = 5'd0; tankDir = 2'b10;
        applyStimulus(1'b1, 1'b1);
        checkPos("t6.spawn", 0, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkPos("t6.exit", 0, 0, 0);
        targetValid = 1'b1; targetX = 5'd12; targetY = 5'd6;
        tankX = 5'd12; tankY = 5'd6; tankDir = 2'b01;
        applyStimulus(1'b1, 1'b1);
        checkPos("t6.onTarget", 12, 6, 1);
        checkFlags("t6.onTarget", 1, 0, 0);
        applyStimulus(1'b0, 1'b1);
        checkPos("t6.hit", 12, 6, 1);
        checkFlags("t6.hit", 1, 1, 1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t6.tick1", 1, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t6.tick2", 1, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkFlags("t6.tick3", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
